// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants for the hazard scoreboard: default latencies, register-file
// geometry and the stall counter width.
package hazard_scoreboard_pkg;

  localparam int unsigned LAT_NOFWD_DFLT = 3;  // EXE, MEM, WB before the RF holds the result
  localparam int unsigned LAT_LOAD_DFLT  = 1;  // load-use bubble with forwarding
  localparam int unsigned CNT_W_DFLT     = 2;  // per-register countdown width
  localparam int unsigned NUM_REGS       = 16;
  localparam int unsigned REG_IDX_W      = 4;
  localparam int unsigned STALL_W        = 32;

endpackage : hazard_scoreboard_pkg

// File: rtl/hazard_scoreboard_if.sv
// ID-stage <-> scoreboard interface.
//  master : ID stage side, drives source/dest decode, forward mode, branch and freeze
//  slave  : scoreboard side, returns hazard, flush, pending mask and stall count
interface hazard_scoreboard_if;
  import hazard_scoreboard_pkg::*;

  logic [REG_IDX_W-1:0] src_1;
  logic [REG_IDX_W-1:0] src_2;
  logic                 two_src;
  logic                 id_wb_en;
  logic                 id_mem_r_en;
  logic [REG_IDX_W-1:0] id_dest;
  logic                 forward_en;
  logic                 branch_taken;
  logic                 freeze;
  logic                 hazard;
  logic                 flush;
  logic [NUM_REGS-1:0]  pending;
  logic [STALL_W-1:0]   stall_cycles;

  modport master (
    output src_1, src_2, two_src, id_wb_en, id_mem_r_en, id_dest,
           forward_en, branch_taken, freeze,
    input  hazard, flush, pending, stall_cycles
  );

  modport slave (
    input  src_1, src_2, two_src, id_wb_en, id_mem_r_en, id_dest,
           forward_en, branch_taken, freeze,
    output hazard, flush, pending, stall_cycles
  );

endinterface : hazard_scoreboard_if

// File: rtl/hazard_scoreboard_entry.sv
// One scoreboard countdown for a single architectural register.
//  clk, rst  : clock, async active-high reset
//  hold      : pipeline frozen; counter keeps its value
//  alloc     : an issuing instruction writes this register
//  alloc_lat : cycles until that write is visible to a reader
//  busy      : counter non-zero (register not yet readable)
module scoreboard_entry #(
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             alloc,
  input  logic [CNT_W-1:0] alloc_lat,
  output logic             busy
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_dec;
  logic [CNT_W-1:0] cnt_nxt;

  // Saturating decrement; a new write keeps the later of the two completions.
  always_comb begin
    cnt_dec = (cnt != '0) ? cnt - CNT_W'(1) : '0;
    cnt_nxt = cnt_dec;
    if (hold) begin
      cnt_nxt = cnt;
    end else if (alloc && (alloc_lat > cnt_dec)) begin
      cnt_nxt = alloc_lat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

  assign busy = (cnt != '0);

endmodule : scoreboard_entry

// File: rtl/hazard_scoreboard.sv
// Per-register hazard scoreboard for the ID stage. Tracks in-flight writes to
// R0-R15 with countdown timers, stalls ID on a read of a busy register, passes
// branch_taken through as flush, and counts unfrozen stall cycles.
//  clk, rst : clock, async active-high reset
//  sb       : slave side of hazard_scoreboard_if (ID decode in; hazard,
//             flush, pending mask, stall_cycles out)
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned LAT_NOFWD = LAT_NOFWD_DFLT,
  parameter int unsigned LAT_LOAD  = LAT_LOAD_DFLT,
  parameter int unsigned CNT_W     = CNT_W_DFLT
) (
  input logic                clk,
  input logic                rst,
  hazard_scoreboard_if.slave sb
);

  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  // Counters must be able to hold the longest allocation latency.
  if ((LAT_NOFWD > CNT_MAX) || (LAT_LOAD > CNT_MAX)) begin : g_lat_check
    $error("hazard_scoreboard: latency does not fit in CNT_W bits");
  end

  logic [NUM_REGS-1:0] busy;
  logic                hazard;
  logic                issue;
  logic [CNT_W-1:0]    alloc_lat;
  logic [STALL_W-1:0]  stall_cnt;

  // A taken branch squashes the ID instruction, so it never stalls.
  assign hazard = (busy[sb.src_1] | (sb.two_src & busy[sb.src_2])) & ~sb.branch_taken;
  assign issue  = ~hazard & ~sb.freeze & ~sb.branch_taken;

  // Latency until the written value can be consumed by a dependent instruction.
  always_comb begin
    alloc_lat = CNT_W'(LAT_NOFWD);
    if (sb.forward_en) begin
      alloc_lat = sb.id_mem_r_en ? CNT_W'(LAT_LOAD) : '0;
    end
  end

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_entry
    logic alloc;
    assign alloc = issue & sb.id_wb_en & (sb.id_dest == REG_IDX_W'(r));

    scoreboard_entry #(
      .CNT_W (CNT_W)
    ) u_entry (
      .clk       (clk),
      .rst       (rst),
      .hold      (sb.freeze),
      .alloc     (alloc),
      .alloc_lat (alloc_lat),
      .busy      (busy[r])
    );
  end

  // Frozen cycles are charged to the memory stage, not to hazards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (hazard && !sb.freeze) begin
      stall_cnt <= stall_cnt + STALL_W'(1);
    end
  end

  assign sb.hazard       = hazard;
  assign sb.flush        = sb.branch_taken;
  assign sb.pending      = busy;
  assign sb.stall_cycles = stall_cnt;

endmodule : hazard_scoreboard
